// File: rtl/db_seq_ctrl_if.sv
// db_seq_ctrl_if
//  Groups the start/stall handshake and the shared state/cnt bus of the
//  deblocking/SAO CTU sequencer.
//  master : CTU scheduler side. Drives start_i, sys_ctu_x_i, sys_ctu_y_i, stall_i
//           and observes ready_o, state_o, cnt_o, sys_ctu_x_o, sys_ctu_y_o, done_o.
//  slave  : sequencer side (db_seq_ctrl).
//  The _i/_o suffixes on the signals are written from the sequencer's point of view.
interface db_seq_ctrl_if #(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8
);
  logic                   start_i;
  logic [PIC_X_WIDTH-1:0] sys_ctu_x_i;
  logic [PIC_Y_WIDTH-1:0] sys_ctu_y_i;
  logic                   stall_i;
  logic                   ready_o;
  logic [2:0]             state_o;
  logic [8:0]             cnt_o;
  logic [PIC_X_WIDTH-1:0] sys_ctu_x_o;
  logic [PIC_Y_WIDTH-1:0] sys_ctu_y_o;
  logic                   done_o;

  modport master (
    output start_i, sys_ctu_x_i, sys_ctu_y_i, stall_i,
    input  ready_o, state_o, cnt_o, sys_ctu_x_o, sys_ctu_y_o, done_o
  );

  modport slave (
    input  start_i, sys_ctu_x_i, sys_ctu_y_i, stall_i,
    output ready_o, state_o, cnt_o, sys_ctu_x_o, sys_ctu_y_o, done_o
  );
endinterface

// File: rtl/db_seq_ctrl.sv
// db_seq_ctrl
//  Per-CTU sequencer for the deblocking/SAO pipeline. On an accepted start it
//  latches the CTU coordinates and steps LOAD->DBY->DBU->DBV->SAO->OUT->IDLE,
//  advancing cnt_o by one per cycle. stall_i freezes the sequence while active.
//  done_o pulses for the single IDLE cycle that follows the last OUT cycle.
// Configuration macro:
//  DB_SAO_EN : when defined the SAO state is part of the sequence; otherwise
//              DBV hands over directly to OUT and code 100 never appears.
// Ports:
//  clk  : clock
//  rst  : synchronous reset, active high
//  bus  : db_seq_ctrl_if.slave
//         start_i, sys_ctu_x_i, sys_ctu_y_i : start request with CTU coordinates
//         stall_i                           : hold state/cnt for this cycle
//         ready_o                           : 1 while IDLE
//         state_o, cnt_o                    : shared state/cnt bus
//         sys_ctu_x_o, sys_ctu_y_o          : latched CTU coordinates
//         done_o                            : one-cycle completion pulse
module db_seq_ctrl #(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int LOAD_CYC    = 65,
  parameter int DBY_CYC     = 256,
  parameter int DBU_CYC     = 64,
  parameter int DBV_CYC     = 64,
  parameter int SAO_CYC     = 128,
  parameter int OUT_CYC     = 128
) (
  input logic         clk,
  input logic         rst,
  db_seq_ctrl_if.slave bus
);

  // State codes are fixed by the consumers of the state bus.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    DBY  = 3'b011,
    DBU  = 3'b010,
    DBV  = 3'b110,
    SAO  = 3'b100,
    OUT  = 3'b101
  } seqState_e;

  localparam logic [8:0] LOAD_LAST = 9'(LOAD_CYC - 1);
  localparam logic [8:0] DBY_LAST  = 9'(DBY_CYC - 1);
  localparam logic [8:0] DBU_LAST  = 9'(DBU_CYC - 1);
  localparam logic [8:0] DBV_LAST  = 9'(DBV_CYC - 1);
  localparam logic [8:0] SAO_LAST  = 9'(SAO_CYC - 1);
  localparam logic [8:0] OUT_LAST  = 9'(OUT_CYC - 1);

  seqState_e              state_q, state_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [PIC_X_WIDTH-1:0] ctuX_q, ctuX_d;
  logic [PIC_Y_WIDTH-1:0] ctuY_q, ctuY_d;
  logic                   done_q, done_d;
  logic [8:0]             lastCnt;

  // State register: all outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctuX_q  <= '0;
      ctuY_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctuX_q  <= ctuX_d;
      ctuY_q  <= ctuY_d;
      done_q  <= done_d;
    end
  end

  // Final cnt value of each active state. SAO keeps an entry even when the
  // state is unreachable so the table stays uniform across builds.
  always_comb begin
    lastCnt = '0;
    case (state_q)
      LOAD:    lastCnt = LOAD_LAST;
      DBY:     lastCnt = DBY_LAST;
      DBU:     lastCnt = DBU_LAST;
      DBV:     lastCnt = DBV_LAST;
      SAO:     lastCnt = SAO_LAST;
      OUT:     lastCnt = OUT_LAST;
      default: lastCnt = '0;
    endcase
  end

  // Next-state logic. Coordinates move only on an accepted start; done is
  // raised on the OUT->IDLE step so it lines up with the first IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctuX_d  = ctuX_q;
    ctuY_d  = ctuY_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (bus.start_i) begin
        state_d = LOAD;
        ctuX_d  = bus.sys_ctu_x_i;
        ctuY_d  = bus.sys_ctu_y_i;
      end
    end else if (!bus.stall_i) begin
      if (cnt_q == lastCnt) begin
        cnt_d = '0;
        case (state_q)
          LOAD: state_d = DBY;
          DBY:  state_d = DBU;
          DBU:  state_d = DBV;
`ifdef DB_SAO_EN
          DBV:  state_d = SAO;
`else
          DBV:  state_d = OUT;
`endif
          SAO:  state_d = OUT;
          OUT: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 9'd1;
      end
    end
  end

  // Output drive from the registered state.
  always_comb begin
    bus.ready_o     = (state_q == IDLE);
    bus.state_o     = state_q;
    bus.cnt_o       = cnt_q;
    bus.sys_ctu_x_o = ctuX_q;
    bus.sys_ctu_y_o = ctuY_q;
    bus.done_o      = done_q;
  end

endmodule

// File: tb/tb_db_seq_ctrl.sv
// tb_db_seq_ctrl
//  Directed bench for db_seq_ctrl: reset, full CTU walk, stall, ignored and
//  back-to-back starts, mid-CTU reset. Follows DB_SAO_EN like the design.
module tb_db_seq_ctrl;

  localparam int XW = 8;
  localparam int YW = 8;
`ifdef DB_SAO_EN
  localparam int TOTAL     = 706;
  localparam int SAW_SAO   = 1;
`else
  localparam int TOTAL     = 578;
  localparam int SAW_SAO   = 0;
`endif

  logic clk;
  logic rst;

  db_seq_ctrl_if #(.PIC_X_WIDTH(XW), .PIC_Y_WIDTH(YW)) bus ();

  db_seq_ctrl #(.PIC_X_WIDTH(XW), .PIC_Y_WIDTH(YW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks    = 0;
  int failures  = 0;
  int elapsed   = 0;
  int doneCount = 0;
  int doneBefore;
  int sawSao    = 0;
  int phaseCode [6];
  int phaseLen  [6];
  int numPhases;

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the scheduler-side inputs.
  task automatic applyStimulus(input logic start, input logic [XW-1:0] x,
                               input logic [YW-1:0] y, input logic stall);
    bus.start_i     = start;
    bus.sys_ctu_x_i = x;
    bus.sys_ctu_y_i = y;
    bus.stall_i     = stall;
  endtask

  // One comparison, counted and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    elapsed++;
    if (bus.done_o === 1'b1) doneCount++;
    if (bus.state_o === 3'b100) sawSao = 1;
  endtask

  // Step until state/cnt reach the target, bounded.
  task automatic runUntil(input string tag, input logic [2:0] s, input logic [8:0] c,
                          input int maxCyc);
    int found;
    found = 0;
    for (int i = 0; i < maxCyc; i++) begin
      if (bus.state_o === s && bus.cnt_o === c) begin
        found = 1;
        break;
      end
      stepCycle();
    end
    checkOutput({tag, " reached"}, 32'(found), 32'd1);
  endtask

  // Step until done_o is seen, bounded.
  task automatic runUntilDone(input string tag, input int maxCyc);
    int found;
    found = 0;
    for (int i = 0; i < maxCyc; i++) begin
      stepCycle();
      if (bus.done_o === 1'b1) begin
        found = 1;
        break;
      end
    end
    checkOutput({tag, " done seen"}, 32'(found), 32'd1);
  endtask

  // Walk a whole CTU from LOAD cnt 0, checking every state/cnt pair per phase.
  task automatic walkCtu(input string tag);
    int bad;
    for (int p = 0; p < numPhases; p++) begin
      bad = 0;
      for (int c = 0; c < phaseLen[p]; c++) begin
        if (bus.state_o !== 3'(phaseCode[p]) || bus.cnt_o !== 9'(c) || bus.done_o !== 1'b0)
          bad++;
        stepCycle();
      end
      checkOutput($sformatf("%s phase %0d walk errors", tag, p), 32'(bad), 32'd0);
    end
  endtask

  // Directed sequence.
  initial begin
`ifdef DB_SAO_EN
    numPhases = 6;
    phaseCode = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    phaseLen  = '{65, 256, 64, 64, 128, 128};
`else
    numPhases = 5;
    phaseCode = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b101, 0};
    phaseLen  = '{65, 256, 64, 64, 128, 0};
`endif

    // Reset held 2 cycles; start and stall must not matter.
    rst = 1'b1;
    applyStimulus(1'b1, 8'd9, 8'd9, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("reset state", 32'(bus.state_o), 32'd0);
    checkOutput("reset cnt", 32'(bus.cnt_o), 32'd0);
    checkOutput("reset ready", 32'(bus.ready_o), 32'd1);
    checkOutput("reset done", 32'(bus.done_o), 32'd0);
    checkOutput("reset x", 32'(bus.sys_ctu_x_o), 32'd0);
    checkOutput("reset y", 32'(bus.sys_ctu_y_o), 32'd0);

    // CTU A: start x=3 y=2, full walk without stall.
    rst = 1'b0;
    applyStimulus(1'b1, 8'd3, 8'd2, 1'b0);
    elapsed = 0;
    stepCycle();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("A start state", 32'(bus.state_o), 32'd1);
    checkOutput("A start cnt", 32'(bus.cnt_o), 32'd0);
    checkOutput("A x latched", 32'(bus.sys_ctu_x_o), 32'd3);
    checkOutput("A y latched", 32'(bus.sys_ctu_y_o), 32'd2);
    checkOutput("A ready low", 32'(bus.ready_o), 32'd0);
    walkCtu("A");
    checkOutput("A done pulse", 32'(bus.done_o), 32'd1);
    checkOutput("A idle on done", 32'(bus.state_o), 32'd0);
    checkOutput("A latency", 32'(elapsed), 32'(TOTAL));
    checkOutput("A done count", 32'(doneCount), 32'd1);
    checkOutput("A x held", 32'(bus.sys_ctu_x_o), 32'd3);

    // CTU B: accepted on the done cycle with x=7 y=5.
    applyStimulus(1'b1, 8'd7, 8'd5, 1'b0);
    elapsed    = 0;
    doneBefore = doneCount;
    stepCycle();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("B back-to-back state", 32'(bus.state_o), 32'd1);
    checkOutput("B done cleared", 32'(bus.done_o), 32'd0);
    checkOutput("B x latched", 32'(bus.sys_ctu_x_o), 32'd7);
    checkOutput("B y latched", 32'(bus.sys_ctu_y_o), 32'd5);

    // Stall 5 cycles at DBY cnt 100.
    runUntil("B DBY 100", 3'b011, 9'd100, 600);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput($sformatf("B stall hold cnt %0d", i), 32'(bus.cnt_o), 32'd100);
    end
    checkOutput("B stall hold state", 32'(bus.state_o), 32'd3);
    bus.stall_i = 1'b0;
    stepCycle();
    checkOutput("B resume cnt", 32'(bus.cnt_o), 32'd101);

    // Start during DBU is ignored.
    runUntil("B DBU 0", 3'b010, 9'd0, 600);
    applyStimulus(1'b1, 8'd9, 8'd9, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("B DBU state kept", 32'(bus.state_o), 32'd2);
    checkOutput("B DBU cnt", 32'(bus.cnt_o), 32'd3);
    checkOutput("B x unchanged", 32'(bus.sys_ctu_x_o), 32'd7);
    checkOutput("B y unchanged", 32'(bus.sys_ctu_y_o), 32'd5);
    runUntilDone("B", 2000);
    checkOutput("B stalled latency", 32'(elapsed), 32'(TOTAL + 5));
    checkOutput("B done count", 32'(doneCount - doneBefore), 32'd1);
    stepCycle();
    checkOutput("B start not queued", 32'(bus.state_o), 32'd0);
    checkOutput("B done one cycle", 32'(bus.done_o), 32'd0);

    // CTU C: reset at DBV cnt 10 aborts without done.
    applyStimulus(1'b1, 8'd1, 8'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    runUntil("C DBV 10", 3'b110, 9'd10, 600);
    doneBefore = doneCount;
    rst = 1'b1;
    stepCycle();
    checkOutput("C abort state", 32'(bus.state_o), 32'd0);
    checkOutput("C abort cnt", 32'(bus.cnt_o), 32'd0);
    checkOutput("C abort done", 32'(bus.done_o), 32'd0);
    checkOutput("C abort x", 32'(bus.sys_ctu_x_o), 32'd0);
    rst = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("C no done after abort", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("C stays idle", 32'(bus.state_o), 32'd0);

    // CTU D: stall ignored in IDLE, then a full CTU.
    applyStimulus(1'b1, 8'd4, 8'd6, 1'b1);
    elapsed    = 0;
    doneBefore = doneCount;
    stepCycle();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
    checkOutput("D start despite stall", 32'(bus.state_o), 32'd1);
    checkOutput("D x latched", 32'(bus.sys_ctu_x_o), 32'd4);
    runUntilDone("D", 2000);
    checkOutput("D latency", 32'(elapsed), 32'(TOTAL));
    checkOutput("D done count", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("SAO code seen", 32'(sawSao), 32'(SAW_SAO));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
